// File: rtl/rgb_fade_sequencer_pkg.sv
// rtl/rgb_fade_sequencer_pkg.sv - shared types, colour table and ramp helper for the RGB fade sequencer
package rgb_seq_pkg;

  localparam int LEVEL_W = 3;
  localparam int PWM_LAST = 6;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef struct packed {
    level_t r;
    level_t g;
    level_t b;
  } rgb_t;

  typedef enum logic [1:0] {IDLE, RAMP, HOLD} seq_state_t;

  // R, Y, G, C, B, M, W, OFF
  localparam rgb_t COLOR_TABLE [8] = '{
    9'o700, 9'o770, 9'o070, 9'o077, 9'o007, 9'o707, 9'o777, 9'o000
  };

  function automatic level_t step_toward(input level_t cur, input level_t tgt);
    if (cur < tgt) return cur + level_t'(1);
    if (cur > tgt) return cur - level_t'(1);
    return cur;
  endfunction

endpackage

// File: rtl/rgb_pwm_gen.sv
// rtl/rgb_pwm_gen.sv - three-channel PWM with one shared 0..6 counter and registered outputs
module rgb_pwm_gen
  import rgb_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  rgb_t       duty,
  output logic [2:0] pwm
);

  level_t cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      pwm <= '0;
    end else begin
      cnt <= (cnt == level_t'(PWM_LAST)) ? '0 : cnt + level_t'(1);
      pwm <= {cnt < duty.b, cnt < duty.g, cnt < duty.r};
    end
  end

endmodule

// File: rtl/rgb_fade_sequencer.sv
// rtl/rgb_fade_sequencer.sv - colour-table fade sequencer with manual override driving LED16 PWM pins
module rgb_fade_sequencer
  import rgb_seq_pkg::*;
#(
  parameter int TICK_DIV   = 10_000_000,
  parameter int HOLD_TICKS = 10
) (
  input  logic       CLK100MHZ,
  input  logic       CPU_RESETN,
  input  logic       en,
  input  logic       step,
  input  logic       manual,
  input  logic [8:0] manual_rgb,
  output logic [2:0] LED16,
  output logic [8:0] duty_rgb,
  output logic [2:0] color_idx,
  output logic       holding
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic [PW-1:0] presc;
  logic [HW-1:0] hold_cnt;
  logic          run;
  logic          tick;
  logic          hold_done;
  seq_state_t    state;
  rgb_t          duty;
  rgb_t          target;
  rgb_t          duty_nxt;

  assign run       = en && !manual;
  assign tick      = run && (presc == PW'(TICK_DIV - 1));
  assign hold_done = (hold_cnt == HW'(HOLD_TICKS - 1));
  assign target    = COLOR_TABLE[color_idx];
  assign duty_nxt  = {step_toward(duty.r, target.r),
                      step_toward(duty.g, target.g),
                      step_toward(duty.b, target.b)};
  assign duty_rgb  = duty;

  // Prescaler keeps its phase while frozen so a resumed run continues the same tick
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      presc <= '0;
    end else if (run) begin
      presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state     <= IDLE;
      duty      <= '0;
      color_idx <= '0;
      hold_cnt  <= '0;
      holding   <= 1'b0;
    end else if (manual) begin
      duty     <= manual_rgb;
      state    <= IDLE;
      hold_cnt <= '0;
      holding  <= 1'b0;
    end else if (en) begin
      unique case (state)
        IDLE: state <= RAMP;
        RAMP: begin
          if (tick) begin
            duty <= duty_nxt;
            if (duty_nxt == target) begin
              state    <= HOLD;
              hold_cnt <= '0;
              holding  <= 1'b1;
            end
          end
        end
        HOLD: begin
          // a step coinciding with the final hold tick still yields a single advance
          if (step || (tick && hold_done)) begin
            color_idx <= color_idx + 3'd1;
            state     <= RAMP;
            hold_cnt  <= '0;
            holding   <= 1'b0;
          end else if (tick) begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rgb_pwm_gen u_pwm (
    .clk   (CLK100MHZ),
    .rst_n (CPU_RESETN),
    .duty  (duty),
    .pwm   (LED16)
  );

endmodule
